// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of an async FIFO: binary/Gray write pointer,
// full / almost-full / level from the synchronized read pointer, sticky overflow.
module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH     = 3,
    parameter int ALMOST_FULL_TH = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  W_INC,
    input  logic [ADDR_WIDTH:0]   WQ2_RPTR,
    input  logic                  OVF_CLR,
    output logic                  W_EN,
    output logic [ADDR_WIDTH-1:0] W_ADDR,
    output logic [ADDR_WIDTH:0]   WPTR_GRAY,
    output logic                  W_FULL,
    output logic                  W_ALMOST_FULL,
    output logic [ADDR_WIDTH:0]   W_LEVEL,
    output logic                  W_OVERFLOW
);

    localparam logic [ADDR_WIDTH:0] AF_TH = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);

    logic [ADDR_WIDTH:0] wbin_q, wbin_d;
    logic [ADDR_WIDTH:0] gray_q, gray_d;
    logic [ADDR_WIDTH:0] level_q, level_d;
    logic [ADDR_WIDTH:0] rbin;
    logic [ADDR_WIDTH:0] full_cmp;
    logic                full_q, full_d;
    logic                af_q, af_d;
    logic                ovf_q, ovf_d;
    logic                accept;

    assign accept = W_INC & ~full_q & ~RST;

    always_comb begin
        rbin = '0;
        for (int i = 0; i <= ADDR_WIDTH; i++) begin
            rbin[i] = ^(WQ2_RPTR >> i);
        end
    end

    // Full when our next Gray pointer equals the read pointer with its two MSBs flipped.
    assign full_cmp = {~WQ2_RPTR[ADDR_WIDTH:ADDR_WIDTH-1],
                       WQ2_RPTR[ADDR_WIDTH-2:0]};

    always_comb begin
        wbin_d  = wbin_q + {{ADDR_WIDTH{1'b0}}, accept};
        gray_d  = wbin_d ^ (wbin_d >> 1);
        full_d  = (gray_d == full_cmp);
        level_d = wbin_d - rbin;
        af_d    = (level_d >= AF_TH);
        ovf_d   = ovf_q;
        if (OVF_CLR) ovf_d = 1'b0;
        if (W_INC && full_q) ovf_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wbin_q  <= '0;
            gray_q  <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            gray_q  <= gray_d;
            full_q  <= full_d;
            af_q    <= af_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    assign W_EN          = accept;
    assign W_ADDR        = wbin_q[ADDR_WIDTH-1:0];
    assign WPTR_GRAY     = gray_q;
    assign W_FULL        = full_q;
    assign W_ALMOST_FULL = af_q;
    assign W_LEVEL       = level_q;
    assign W_OVERFLOW    = ovf_q;

endmodule
